sha256_msg_padder: RTL and testbench

Upstream stage of the SHA-256 hasher. On start it reads num_words 32-bit message words from memory beginning at message_addr. It applies SHA-256 padding: a 0x80000000 word, zero fill, then a 64-bit big-endian bit length. The result is presented as a sequence of 512-bit blocks over a valid/ready handshake to the compression core, which no longer reads or pads the message itself.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_msg_padder.sv | 148 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constant, padder
// state encoding and the block-count helper used by padder, core and bench.
package sha256_pkg;

    localparam int          WORDS_PER_BLOCK = 16;
    localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } padder_state_t;

    // Element [15] is word 0 so that word 0 lands in bits [511:480].
    typedef logic [15:0][31:0] block_t;

    // Blocks needed for n message words plus the pad word and 64-bit length.
    function automatic logic [15:0] num_blocks(input logic [15:0] n);
        logic [16:0] t;
        t = {1'b0, n} + 17'd2;
        return 16'(t[16:4]) + 16'd1;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams message words from a synchronous SRAM,
// appends the 0x80000000 marker, zero fill and 64-bit bit length, and hands
// complete 512-bit blocks to the compression core over valid/ready.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    input  logic [15:0]  num_words,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic         busy,
    output logic         done
);

    padder_state_t       state_q;
    logic [15:0]         base_q;
    logic [15:0]         n_q;
    logic [15:0]         nblk_q;
    logic [15:0]         blk_idx_q;
    logic [4:0]          iss_q;
    logic [4:0]          cap_q;
    logic [RD_LAT-1:0]   rd_sr_q;
    block_t              buf_q;

    logic [15:0]         n_clamp;
    logic [15:0]         blk_base;
    logic [4:0]          k_words;
    logic                issue_now;

    assign mem_clk  = clk;
    assign mem_we   = 1'b0;
    assign blk_data = buf_q;

    // Pad image of one block; message slots are overwritten by SRAM data later.
    function automatic block_t pad_block(input logic [15:0] blk,
                                         input logic [15:0] n,
                                         input logic [15:0] nblk);
        block_t      b;
        logic [15:0] g;
        b = '0;
        for (int s = 0; s < WORDS_PER_BLOCK; s++) begin
            g = {blk[11:0], 4'd0} + 16'(s);
            if ((blk == nblk - 16'd1) && (s == WORDS_PER_BLOCK - 1))
                b[15-s] = {16'd0, n} << 5;
            else if (g == n)
                b[15-s] = PAD_WORD;
        end
        return b;
    endfunction

    // Clamp request length and work out how many words of this block come from memory.
    always_comb begin
        n_clamp   = (num_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : num_words;
        blk_base  = {blk_idx_q[11:0], 4'd0};
        k_words   = 5'd0;
        if (n_q > blk_base)
            k_words = ((n_q - blk_base) >= 16'd16) ? 5'd16 : 5'(n_q - blk_base);
        issue_now = (state_q == ST_FILL) && (iss_q < k_words);
    end

    // Control FSM with read pipeline, block buffer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            n_q       <= '0;
            nblk_q    <= '0;
            blk_idx_q <= '0;
            iss_q     <= '0;
            cap_q     <= '0;
            rd_sr_q   <= '0;
            buf_q     <= '0;
            mem_addr  <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Bit RD_LAT-1 marks the cycle in which the oldest read's data is on the bus.
            rd_sr_q <= {rd_sr_q[RD_LAT-2:0], issue_now};
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q    <= message_addr;
                        n_q       <= n_clamp;
                        nblk_q    <= num_blocks(n_clamp);
                        blk_idx_q <= '0;
                        iss_q     <= '0;
                        cap_q     <= '0;
                        buf_q     <= pad_block(16'd0, n_clamp, num_blocks(n_clamp));
                        busy      <= 1'b1;
                        state_q   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (issue_now) begin
                        mem_addr <= base_q + blk_base + {11'd0, iss_q};
                        iss_q    <= iss_q + 5'd1;
                    end
                    if (rd_sr_q[RD_LAT-1]) begin
                        buf_q[4'd15 - cap_q[3:0]] <= mem_read_data;
                        cap_q                     <= cap_q + 5'd1;
                    end
                    if (cap_q == k_words) begin
                        blk_valid <= 1'b1;
                        blk_last  <= (blk_idx_q == nblk_q - 16'd1);
                        state_q   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (blk_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            blk_idx_q <= blk_idx_q + 16'd1;
                            iss_q     <= '0;
                            cap_q     <= '0;
                            buf_q     <= pad_block(blk_idx_q + 16'd1, n_q, nblk_q);
                            state_q   <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: an SRAM model feeds the padder,
// a reference padding model queues expected blocks, and a monitor checks
// accepted blocks, stall stability and the read address sequence.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  message_addr = '0;
    logic [15:0]  num_words = '0;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_read_data = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         busy;
    logic         done;

    sha256_msg_padder dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .message_addr(message_addr), .num_words(num_words),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } exp_blk_t;

    exp_blk_t     sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           mem_mode = 0;
    logic [15:0]  cur_base = '0;
    logic [31:0]  seed = '0;
    int           ready_mode = 0;
    int           rdy_cnt = 0;
    logic         trk_on = 1'b0;
    logic [15:0]  trk_last = '0;
    logic [15:0]  exp_addr = '0;
    int           rd_cnt = 0;
    int           acc_cnt = 0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic         prev_last = 1'b0;
    logic [511:0] prev_data = '0;
    logic [15:0]  prev_addr = '0;

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        logic [15:0] off;
        if (mem_mode == 0) begin
            off = a - cur_base;
            return {16'd0, off} + 32'd1;
        end
        return ({16'd0, a} * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Synchronous SRAM fed by the padder's registered address.
    always @(posedge clk) mem_read_data <= mem_fn(mem_addr);

    // Consumer ready pattern: always ready, five-cycle stall per block, or random.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: blk_ready = 1'b1;
            1: begin
                if (blk_valid) begin
                    rdy_cnt++;
                    blk_ready = (rdy_cnt >= 6);
                end else begin
                    rdy_cnt   = 0;
                    blk_ready = 1'b0;
                end
            end
            default: blk_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: read sequence, stall stability, and scoreboard compare on acceptance.
    always @(negedge clk) begin
        if (reset_n) begin
            if (trk_on && (mem_addr != trk_last)) begin
                chk("read_addr", {496'd0, mem_addr}, {496'd0, exp_addr});
                exp_addr = exp_addr + 16'd1;
                rd_cnt++;
                trk_last = mem_addr;
            end
            if (blk_valid && prev_valid && !prev_ready) begin
                chk("stall_data", blk_data, prev_data);
                chk("stall_last", {511'd0, blk_last}, {511'd0, prev_last});
                chk("stall_addr", {496'd0, mem_addr}, {496'd0, prev_addr});
            end
            if (blk_valid && blk_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got %h expected none", blk_data);
                end else begin
                    exp_blk_t e;
                    e = sb_q.pop_front();
                    chk("blk_data", blk_data, e.data);
                    chk("blk_last", {511'd0, blk_last}, {511'd0, e.last});
                end
                acc_cnt++;
            end
        end
        prev_valid = blk_valid;
        prev_ready = blk_ready;
        prev_last  = blk_last;
        prev_data  = blk_data;
        prev_addr  = mem_addr;
    end

    // Reference padding: message, marker word, zeros to 14 mod 16, then 64-bit length.
    task automatic build_expected(input logic [15:0] base, input int n);
        logic [31:0] w[$];
        exp_blk_t    e;
        int          nb;
        for (int i = 0; i < n; i++) w.push_back(mem_fn(base + 16'(i)));
        w.push_back(32'h8000_0000);
        while ((w.size() % 16) != 14) w.push_back(32'd0);
        w.push_back(32'd0);
        w.push_back(32'(n * 32));
        nb = w.size() / 16;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < 16; j++) e.data[511 - 32*j -: 32] = w[16*b + j];
            e.last = (b == nb - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic run_op(input logic [15:0] base_in, input logic [15:0] nw, input int rmode,
                          input int mmode, input bit busy_start, input bit abort);
        logic [15:0] base;
        int          n, nblk_exp, lat, lat_exp, k;
        bit          seen;
        base = base_in;
        if (base == mem_addr) base = base + 16'h0100;
        n          = (nw > 16'd1024) ? 1024 : int'(nw);
        mem_mode   = mmode;
        cur_base   = base;
        seed       = $urandom;
        ready_mode = rmode;
        sb_q.delete();
        build_expected(base, n);
        nblk_exp = sb_q.size();
        acc_cnt  = 0;
        rd_cnt   = 0;
        exp_addr = base;
        trk_last = mem_addr;
        trk_on   = 1'b1;
        @(posedge clk);
        #1;
        message_addr = base;
        num_words    = nw;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        message_addr = 16'($urandom);
        num_words    = 16'($urandom);
        chk("busy_after_start", {511'd0, busy}, 512'd1);
        lat = 0;
        while (!blk_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        k       = (n > 16) ? 16 : n;
        lat_exp = (k == 0) ? 1 : k + 3;
        chk("first_block_latency", 512'(lat), 512'(lat_exp));
        if (busy_start) begin
            @(posedge clk);
            #1;
            message_addr = base + 16'h0040;
            num_words    = 16'd3;
            start        = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (abort) begin
            for (int i = 0; i < 200 && acc_cnt < 1; i++) @(posedge clk);
            repeat (2) @(posedge clk);
            #3;
            trk_on  = 1'b0;
            reset_n = 1'b0;
            #1;
            chk("rst_blk_valid", {511'd0, blk_valid}, 512'd0);
            chk("rst_blk_last", {511'd0, blk_last}, 512'd0);
            chk("rst_blk_data", blk_data, 512'd0);
            chk("rst_busy", {511'd0, busy}, 512'd0);
            chk("rst_done", {511'd0, done}, 512'd0);
            chk("rst_mem_addr", {496'd0, mem_addr}, 512'd0);
            sb_q.delete();
            @(negedge clk);
            #1;
            reset_n = 1'b1;
            return;
        end
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", {511'd0, seen}, 512'd1);
        if (seen) begin
            chk("busy_at_done", {511'd0, busy}, 512'd0);
            chk("valid_at_done", {511'd0, blk_valid}, 512'd0);
            @(negedge clk);
            chk("done_one_cycle", {511'd0, done}, 512'd0);
        end
        trk_on = 1'b0;
        chk("blocks_accepted", 512'(acc_cnt), 512'(nblk_exp));
        chk("leftover_expected", 512'(sb_q.size()), 512'd0);
        chk("read_count", 512'(rd_cnt), 512'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_addr", {496'd0, mem_addr}, 512'd0);
        chk("reset_blk_valid", {511'd0, blk_valid}, 512'd0);
        chk("reset_blk_last", {511'd0, blk_last}, 512'd0);
        chk("reset_blk_data", blk_data, 512'd0);
        chk("reset_busy", {511'd0, busy}, 512'd0);
        chk("reset_done", {511'd0, done}, 512'd0);
        chk("mem_we", {511'd0, mem_we}, 512'd0);
        chk("mem_clk", {511'd0, mem_clk}, {511'd0, clk});
        @(negedge clk);
        reset_n = 1'b1;

        run_op(16'h0010, 16'd13, 0, 0, 1'b0, 1'b0);
        run_op(16'h0400, 16'd14, 0, 1, 1'b0, 1'b0);
        run_op(16'h0100, 16'd20, 0, 1, 1'b0, 1'b0);
        run_op(16'h0800, 16'd0,  0, 1, 1'b0, 1'b0);
        run_op(16'h0900, 16'd20, 1, 1, 1'b1, 1'b0);
        run_op(16'h0A00, 16'd20, 0, 1, 1'b0, 1'b1);
        run_op(16'h0B00, 16'd13, 0, 0, 1'b0, 1'b0);
        run_op(16'hFFF8, 16'd20, 2, 1, 1'b0, 1'b0);
        run_op(16'h1000, 16'd1100, 2, 1, 1'b0, 1'b0);
        repeat (8) run_op(16'($urandom), 16'($urandom_range(0, 40)), $urandom_range(0, 2), 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
